// File: rtl/cpu_pkg.sv
// Shared CPU package: default widths/sizes for the register file and the
// architectural register-count constant (r15 is the PC, so general-purpose
// registers are r0..r14).
package cpu_pkg;

  localparam int REG_PC       = 15;
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 4;
  localparam int NUM_REGS_DEF = REG_PC;
  localparam int NUM_RD_DEF   = 2;
  localparam int CNT_W_DEF    = 2;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue/writeback bundle between the pipeline and the register file
// scoreboard.
//   master : pipeline side (drives read addresses, issue, writeback)
//   slave  : register file side (returns read data, hazard, issue_ready,
//            pend_any)
interface regfile_scoreboard_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_use;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     hazard;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_dst;
  logic                     issue_ready;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_dst;
  logic [DATA_W-1:0]        wb_data;
  logic                     pend_any;

  modport master (
    output rd_addr, rd_use, issue_en, issue_dst, wb_en, wb_dst, wb_data,
    input  rd_data, hazard, issue_ready, pend_any
  );

  modport slave (
    input  rd_addr, rd_use, issue_en, issue_dst, wb_en, wb_dst, wb_data,
    output rd_data, hazard, issue_ready, pend_any
  );

endinterface

// File: rtl/pend_counter.sv
// Per-register pending-write counter.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : an instruction writing this register issued
//   dec      : a writeback to this register completed
//   cnt      : current count
//   cnt_nxt  : value the counter takes at the next edge
// Saturates at all-ones and never underflows below zero; inc and dec
// together cancel.
module pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_nxt = cnt_q;
    if (inc && !dec && cnt_q != CNT_MAX) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_nxt = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together at the edge regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass and a per-register pending-write
// scoreboard.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of regfile_scoreboard_if
//     rd_addr/rd_use -> rd_data (combinational reads), hazard (stall decode)
//     issue_en/issue_dst -> issue_ready (destination counter has room)
//     wb_en/wb_dst/wb_data : register writeback
//     pend_any : registered OR of all pending counters
// Addresses >= NUM_REGS read as zero and are ignored for writes/issues.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  regfile_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [CNT_W-1:0]  pend_cnt [NUM_REGS];
  logic [CNT_W-1:0]  pend_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [ADDR_W-1:0] rd_addr_a [NUM_RD];

  logic wb_valid;
  logic issue_ready;
  logic pend_any_q;
  logic any_nxt;

  assign wb_valid = bus.wb_en && in_range(bus.wb_dst);

  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr_a[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // A full destination counter blocks issue unless a writeback to the same
  // register drains one slot this cycle.
  always_comb begin
    issue_ready = 1'b1;
    if (in_range(bus.issue_dst) && pend_cnt[bus.issue_dst] == CNT_MAX &&
        !(wb_valid && bus.wb_dst == bus.issue_dst)) begin
      issue_ready = 1'b0;
    end
  end

  assign bus.issue_ready = issue_ready;

  // Operand hazard: an outstanding write that is not being retired this
  // cycle. The decoding instruction's own issue only counts from next cycle.
  always_comb begin
    logic             raw;
    logic [CNT_W-1:0] cnt;
    logic             wb_hit;
    raw    = 1'b0;
    cnt    = '0;
    wb_hit = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (bus.rd_use[k] && in_range(rd_addr_a[k])) begin
        cnt    = pend_cnt[rd_addr_a[k]];
        wb_hit = wb_valid && bus.wb_dst == rd_addr_a[k];
        if (cnt != '0 && !(cnt == CNT_W'(1) && wb_hit)) begin
          raw = 1'b1;
        end
      end
    end
    bus.hazard = raw || (bus.issue_en && !issue_ready);
  end

  // Combinational reads with write-through bypass.
  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (wb_valid && bus.wb_dst == rd_addr_a[k]) begin
        bus.rd_data[k*DATA_W +: DATA_W] = bus.wb_data;
      end else if (in_range(rd_addr_a[k])) begin
        bus.rd_data[k*DATA_W +: DATA_W] = regs[rd_addr_a[k]];
      end
    end
  end

  // NOTE: the register array is reset because reads after reset must return
  // zero; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_valid) begin
      regs[bus.wb_dst] <= bus.wb_data;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
    assign inc[r] = bus.issue_en && issue_ready && bus.issue_dst == ADDR_W'(r);
    assign dec[r] = bus.wb_en && bus.wb_dst == ADDR_W'(r);

    pend_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[r]),
      .dec     (dec[r]),
      .cnt     (pend_cnt[r]),
      .cnt_nxt (pend_nxt[r])
    );
  end

  always_comb begin
    any_nxt = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      any_nxt = any_nxt | (pend_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_any_q <= 1'b0;
    end else begin
      pend_any_q <= any_nxt;
    end
  end

  assign bus.pend_any = pend_any_q;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter NUM_REGS, default 15, number of architectural registers (r0..r14); legal range 2..16.
REQ-003 Parameter ADDR_W, default 4, register address width; SHALL satisfy 2**ADDR_W >= NUM_REGS.
REQ-004 Parameter NUM_RD, default 2, number of read ports; legal range 1..4.
REQ-005 Parameter CNT_W, default 2, width of the per-register pending-write counter.
REQ-006 clk  input  1  the single clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 rd_use  input  NUM_RD  per-port flag: the instruction in decode actually consumes that operand.
REQ-010 rd_data  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-011 hazard  output  1  the decoded instruction must stall.
REQ-012 issue_en  input  1  the decoded instruction issues and will write issue_dst.
REQ-013 issue_dst  input  ADDR_W  destination of the issuing instruction.
REQ-014 issue_ready  output  1  the issue_dst counter can accept one more pending write.
REQ-015 wb_en  input  1  writeback valid.
REQ-016 wb_dst  input  ADDR_W  writeback address.
REQ-017 wb_data  input  DATA_W  writeback data.
REQ-018 pend_any  output  1  registered; high when any pending counter is non-zero.

Function
REQ-019 A write SHALL store wb_data into register wb_dst on the rising clock edge when wb_en=1 and wb_dst<NUM_REGS; writes with wb_dst>=NUM_REGS SHALL be ignored.
REQ-020 Read ports are combinational: rd_data[k] SHALL equal the register at rd_addr[k], or 0 when rd_addr[k]>=NUM_REGS.
REQ-021 Write-through bypass: when wb_en=1 and wb_dst==rd_addr[k]<NUM_REGS, rd_data[k] SHALL equal wb_data in the same cycle.
REQ-022 Each register SHALL have a CNT_W-bit pending counter pend[r].
REQ-023 Counter update for register r: issue only -> pend[r]+1; writeback only -> pend[r]-1; both in the same cycle -> unchanged.
REQ-024 A writeback to r with pend[r]=0 SHALL leave the counter at 0; this is an underflow error case with no wrap.
REQ-025 issue_ready SHALL be 0 when pend[issue_dst]==2**CNT_W-1 and no same-cycle writeback to issue_dst exists; otherwise 1. It is combinational.
REQ-026 An issue_en asserted while issue_ready=0 SHALL be ignored; the counter must not wrap.
REQ-027 hazard SHALL be 1 when any port k has rd_use[k]=1, rd_addr[k]<NUM_REGS, and pend[rd_addr[k]] minus (1 if same-cycle writeback to rd_addr[k] else 0) is greater than 0.
REQ-028 hazard SHALL also be 1 when issue_en=1 and issue_ready=0.
REQ-029 hazard SHALL NOT be affected by the same-cycle issue_en of the instruction being decoded; issue takes effect from the next cycle.
REQ-030 Issue to an address >=NUM_REGS SHALL have no effect.
REQ-031 pend_any SHALL be the OR of all counters after the edge update, registered (1-cycle latency).

Reset
REQ-032 While rst=1, asynchronously: all registers SHALL be 0, all pending counters 0, and pend_any 0.
REQ-033 After reset, rd_data=0 for every address, hazard=0 and issue_ready=1.
REQ-034 An issue_en or wb_en coincident with reset SHALL be discarded; reset mid-operation drops all outstanding pending state.

Structure
REQ-035 The shared package (cpu_pkg) SHALL hold the DATA_W/ADDR_W/NUM_REGS defaults and the register-count constant REG_PC=15.
REQ-036 The per-register counter with its saturate/no-underflow logic SHALL be one sub-module, pend_counter, instantiated NUM_REGS times.

Verification
REQ-037 Reset, then write r3=0x0000_00A5; the next cycle read port0 addr 3 -> 0xA5, and port1 addr 15 -> 0.
REQ-038 wb_en=1, wb_dst=5, wb_data=0x1234 with rd_addr0=5 in the same cycle -> rd_data0=0x1234 combinationally.
REQ-039 Issue r2; the next cycle rd_addr1=2 with rd_use1=1 -> hazard=1; with rd_use1=0 -> hazard=0; writeback r2 in the same cycle as the read -> hazard=0.
REQ-040 Issue r7 three times (CNT_W=2) -> issue_ready=0; a fourth issue is ignored and hazard=1; one writeback to r7 -> issue_ready=1 and the counter is 2.
REQ-041 Issue and writeback to r4 in the same cycle with pend[4]=1 -> pend[4] stays 1 and pend_any stays 1.
REQ-042 Assert rst asynchronously mid-cycle with pend[1]=2 -> pend_any=0 and all rd_data=0 before the next edge.
